// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing/lock generator.
// Also holds the reference 640x480 timing, given as inclusive region ends.
package video_timing_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  localparam logic [1:0] TP_PASS  = 2'd0;
  localparam logic [1:0] TP_BARS  = 2'd1;
  localparam logic [1:0] TP_RAMP  = 2'd2;
  localparam logic [1:0] TP_CHECK = 2'd3;

  // 640x480@60: sync 96/2, back porch 48/33, active 640/480, front porch 16/10
  localparam int VGA_HS_END   = 95;
  localparam int VGA_HBP_END  = 143;
  localparam int VGA_HACT_END = 783;
  localparam int VGA_HFP_END  = 799;
  localparam int VGA_VS_END   = 1;
  localparam int VGA_VBP_END  = 34;
  localparam int VGA_VACT_END = 514;
  localparam int VGA_VFP_END  = 524;

endpackage

// File: rtl/video_tpg.sv
// Combinational test-pattern generator: colour bars, horizontal ramp, checkerboard.
// Only instantiated when VIDEO_TPG_EN is defined; x/y are active-region coordinates.
module video_tpg
  import video_timing_pkg::*;
#(
  parameter int CH        = 3,
  parameter int BPC       = 8,
  parameter int CNT_W     = 12,
  parameter int BAR_SHIFT = 6
) (
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_x,
  input  logic [CNT_W-1:0]  i_y,
  input  logic [CH*BPC-1:0] i_pix,
  output logic [CH*BPC-1:0] o_pix
);

  logic [2:0] bar_idx;
  logic       check_on;
  logic       xy_unused;

  assign xy_unused = ^{i_x, i_y};

  always_comb begin
    bar_idx  = i_x[BAR_SHIFT+2:BAR_SHIFT];
    check_on = i_x[5] ^ i_y[5];
    o_pix    = i_pix;
    case (i_mode)
      TP_BARS: begin
        for (int c = 0; c < CH; c++) begin
          o_pix[c*BPC +: BPC] = {BPC{bar_idx[c % 3]}};
        end
      end
      TP_RAMP: begin
        for (int c = 0; c < CH; c++) begin
          o_pix[c*BPC +: BPC] = i_x[BPC-1:0];
        end
      end
      TP_CHECK: o_pix = {(CH*BPC){check_on}};
      default:  o_pix = i_pix;
    endcase
  end

endmodule

// File: rtl/video_timing_lock_gen.sv
// Programmable DE/HS/VS generator whose counters phase-lock to the rising edge of I_VRST.
// Define VIDEO_TPG_EN to replace pass-through pixels with the I_TP_MODE test patterns.
module video_timing_lock_gen
  import video_timing_pkg::*;
#(
  parameter int CH          = 3,
  parameter int BPC         = 8,
  parameter int CNT_W       = 12,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_MAX    = 3,
  parameter int BAR_SHIFT   = 6
) (
  input  logic              I_PCLK,
  input  logic              I_RST,
  input  logic [CH*BPC-1:0] I_PIX_DATA,
  input  logic              I_VRST,
  input  logic [1:0]        I_TP_MODE,
  input  logic [CNT_W-1:0]  I_HS_END,
  input  logic [CNT_W-1:0]  I_HBP_END,
  input  logic [CNT_W-1:0]  I_HACT_END,
  input  logic [CNT_W-1:0]  I_HFP_END,
  input  logic [CNT_W-1:0]  I_VS_END,
  input  logic [CNT_W-1:0]  I_VBP_END,
  input  logic [CNT_W-1:0]  I_VACT_END,
  input  logic [CNT_W-1:0]  I_VFP_END,
  output logic              O_DE,
  output logic              O_HS,
  output logic              O_VS,
  output logic [CNT_W-1:0]  O_HCNT,
  output logic [CNT_W-1:0]  O_VCNT,
  output logic [CH*BPC-1:0] O_PIX_DATA,
  output logic              O_LOCKED
);

  localparam int PIX_W  = CH * BPC;
  localparam int LCK_W  = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  logic [CNT_W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic              vrst_q, vrst_d;
  lock_state_e       state_q, state_d;
  logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              h_wrap, v_wrap, frame_wrap, vrst_rise, realign;
  logic              h_act, v_act, hs_act, vs_act;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d, locked_q, locked_d;
  logic [CNT_W-1:0]  hcnt_out_q, hcnt_out_d, vcnt_out_q, vcnt_out_d;
  logic [PIX_W-1:0]  pix_q, pix_d, pix_src;

  // Counter stage: free-running raster position with strobe realignment
  always_comb begin
    h_wrap     = (hcnt_q >= I_HFP_END);
    v_wrap     = (vcnt_q >= I_VFP_END);
    frame_wrap = h_wrap & v_wrap;
    vrst_d     = I_VRST;
    vrst_rise  = I_VRST & ~vrst_q;
    // a strobe landing on the natural wrap is aligned even after a timing reprogram
    realign    = vrst_rise & ~frame_wrap;
    hcnt_d     = hcnt_q + CNT_W'(1);
    vcnt_d     = vcnt_q;
    if (realign) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = v_wrap ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      vrst_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      vrst_q <= vrst_d;
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    miss_d     = miss_q;
    case (state_q)
      UNLOCKED: begin
        if (vrst_rise) begin
          lock_cnt_d = LCK_W'(1);
          miss_d     = '0;
          state_d    = (LOCK_FRAMES <= 1) ? LOCKED : LOCKING;
        end
      end
      LOCKING: begin
        if (vrst_rise && frame_wrap) begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
          if (int'(lock_cnt_q) + 1 >= LOCK_FRAMES) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end else if (vrst_rise) begin
          lock_cnt_d = LCK_W'(1);
        end else if (frame_wrap) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (vrst_rise && frame_wrap) begin
          miss_d = '0;
        end else if (vrst_rise) begin
          state_d    = LOCKING;
          lock_cnt_d = LCK_W'(1);
        end else if (frame_wrap) begin
          miss_d = miss_q + MISS_W'(1);
          if (int'(miss_q) + 1 >= MISS_MAX) begin
            state_d = UNLOCKED;
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
  end

`ifdef VIDEO_TPG_EN
  logic [CNT_W-1:0] tp_x, tp_y;

  assign tp_x = hcnt_q - I_HBP_END - CNT_W'(1);
  assign tp_y = vcnt_q - I_VBP_END - CNT_W'(1);

  video_tpg #(
    .CH       (CH),
    .BPC      (BPC),
    .CNT_W    (CNT_W),
    .BAR_SHIFT(BAR_SHIFT)
  ) u_tpg (
    .i_mode(I_TP_MODE),
    .i_x   (tp_x),
    .i_y   (tp_y),
    .i_pix (I_PIX_DATA),
    .o_pix (pix_src)
  );
`else
  logic tp_mode_unused;

  assign tp_mode_unused = ^I_TP_MODE;
  assign pix_src        = I_PIX_DATA;
`endif

  // Decode stage: registered syncs, DE and gated pixel, aligned with the counter copies
  always_comb begin
    hs_act     = (hcnt_q <= I_HS_END);
    vs_act     = (vcnt_q <= I_VS_END);
    h_act      = (hcnt_q > I_HBP_END) && (hcnt_q <= I_HACT_END);
    v_act      = (vcnt_q > I_VBP_END) && (vcnt_q <= I_VACT_END);
    de_d       = h_act & v_act;
    hs_d       = hs_act ? SYNC_POL : ~SYNC_POL;
    vs_d       = vs_act ? SYNC_POL : ~SYNC_POL;
    hcnt_out_d = hcnt_q;
    vcnt_out_d = vcnt_q;
    pix_d      = (de_d && !I_RST) ? pix_src : '0;
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      de_q       <= 1'b0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      hcnt_out_q <= '0;
      vcnt_out_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hcnt_out_q <= hcnt_out_d;
      vcnt_out_q <= vcnt_out_d;
      locked_q   <= locked_d;
    end
  end

  always_ff @(posedge I_PCLK) begin
    pix_q <= pix_d;
  end

  assign O_DE       = de_q;
  assign O_HS       = hs_q;
  assign O_VS       = vs_q;
  assign O_HCNT     = hcnt_out_q;
  assign O_VCNT     = vcnt_out_q;
  assign O_PIX_DATA = pix_q;
  assign O_LOCKED   = locked_q;

endmodule
